// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between the core (fixed priority) and a DMA/loader engine.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_stall,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,

    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    input  logic              i_dma_hold,
    output logic              o_dma_gnt,
    output logic              o_dma_hold_ack,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_dma_rdata,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       o_core_stall_cnt,
    output logic [31:0]       o_dma_grant_cnt
`endif
);

    typedef enum logic [1:0] {
        StShared,
        StDrain,
        StHold
    } state_e;

    typedef enum logic [1:0] {
        OwnNone,
        OwnCore,
        OwnDma
    } owner_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e            r_state;
    owner_e            r_rd_owner;
    logic [3:0]        r_starve_cnt;
    logic              r_hold_ack;
    logic [DATA_W-1:0] r_core_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_core_gnt;
    logic              w_dma_gnt;
    logic              w_core_rvalid;
    logic              w_dma_rvalid;
    logic              w_contended_core_win;

    // Core wins contention unless DMA has been starved for STARVE_LIMIT contended cycles.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dma_gnt  = 1'b0;
        unique case (r_state)
            StShared: begin
                if (i_core_req && i_dma_req) begin
                    if (r_starve_cnt == StarveMax) begin
                        w_dma_gnt = 1'b1;
                    end else begin
                        w_core_gnt = 1'b1;
                    end
                end else begin
                    w_core_gnt = i_core_req;
                    w_dma_gnt  = i_dma_req;
                end
            end
            StHold: begin
                w_dma_gnt = i_dma_req;
            end
            default: begin
                w_core_gnt = 1'b0;
                w_dma_gnt  = 1'b0;
            end
        endcase
    end

    assign w_contended_core_win = w_core_gnt & i_dma_req;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        if (w_core_gnt) begin
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_we    = i_core_we;
        end else if (w_dma_gnt) begin
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
            o_mem_we    = i_dma_we;
        end
    end

    // A return pending across a reset edge must not surface, so rvalid is masked by reset.
    assign w_core_rvalid = (r_rd_owner == OwnCore) && !i_rst;
    assign w_dma_rvalid  = (r_rd_owner == OwnDma) && !i_rst;

    always_comb begin
        o_core_gnt     = w_core_gnt;
        o_dma_gnt      = w_dma_gnt;
        o_core_stall   = i_core_req & ~w_core_gnt;
        o_core_rvalid  = w_core_rvalid;
        o_dma_rvalid   = w_dma_rvalid;
        o_dma_hold_ack = r_hold_ack;
        o_core_rdata   = w_core_rvalid ? i_mem_rdata : r_core_rdata;
        o_dma_rdata    = w_dma_rvalid ? i_mem_rdata : r_dma_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StShared;
            r_hold_ack   <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_rd_owner   <= OwnNone;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else begin
            unique case (r_state)
                StShared: begin
                    if (i_dma_hold) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (i_dma_hold) begin
                        r_state    <= StHold;
                        r_hold_ack <= 1'b1;
                    end else begin
                        r_state <= StShared;
                    end
                end
                StHold: begin
                    if (!i_dma_hold) begin
                        r_state    <= StShared;
                        r_hold_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= StShared;
                    r_hold_ack <= 1'b0;
                end
            endcase

            if (w_dma_gnt || !i_dma_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_contended_core_win && (r_starve_cnt != StarveMax)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (w_core_gnt && !i_core_we) begin
                r_rd_owner <= OwnCore;
            end else if (w_dma_gnt && !i_dma_we) begin
                r_rd_owner <= OwnDma;
            end else begin
                r_rd_owner <= OwnNone;
            end

            // Keep the last returned word visible on each port between returns.
            if (w_core_rvalid) begin
                r_core_rdata <= i_mem_rdata;
            end
            if (w_dma_rvalid) begin
                r_dma_rdata <= i_mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_core_stall_cnt;
    logic [31:0] r_dma_grant_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_core_stall_cnt <= 32'd0;
            r_dma_grant_cnt  <= 32'd0;
        end else begin
            if (i_core_req && !w_core_gnt) begin
                r_core_stall_cnt <= r_core_stall_cnt + 32'd1;
            end
            if (w_dma_gnt) begin
                r_dma_grant_cnt <= r_dma_grant_cnt + 32'd1;
            end
        end
    end

    assign o_core_stall_cnt = r_core_stall_cnt;
    assign o_dma_grant_cnt  = r_dma_grant_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a behavioural reference model.
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;

    localparam int unsigned LIM = 4;

    typedef struct packed {
        logic        rst;
        logic        core_req;
        logic        core_we;
        logic [31:0] core_addr;
        logic [31:0] core_wdata;
        logic        dma_req;
        logic        dma_we;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic        dma_hold;
    } stim_t;

    typedef struct packed {
        logic        core_gnt;
        logic        core_stall;
        logic        core_rv;
        logic        dma_gnt;
        logic        ack;
        logic        dma_rv;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] core_rdata;
        logic [31:0] dma_rdata;
        logic [31:0] stall_cnt;
        logic [31:0] dgnt_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_hold, dma_gnt, dma_hold_ack, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] stall_cnt_o, dgnt_cnt_o;

    int          n_checks = 0;
    int          n_err    = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(LIM)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_core_req    (core_req),
        .i_core_we     (core_we),
        .i_core_addr   (core_addr),
        .i_core_wdata  (core_wdata),
        .o_core_gnt    (core_gnt),
        .o_core_stall  (core_stall),
        .o_core_rvalid (core_rvalid),
        .o_core_rdata  (core_rdata),
        .i_dma_req     (dma_req),
        .i_dma_we      (dma_we),
        .i_dma_addr    (dma_addr),
        .i_dma_wdata   (dma_wdata),
        .i_dma_hold    (dma_hold),
        .o_dma_gnt     (dma_gnt),
        .o_dma_hold_ack(dma_hold_ack),
        .o_dma_rvalid  (dma_rvalid),
        .o_dma_rdata   (dma_rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .o_mem_we      (mem_we),
        .i_mem_rdata   (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .o_core_stall_cnt(stall_cnt_o),
        .o_dma_grant_cnt (dgnt_cnt_o)
`endif
    );

`ifndef ARB_PERF_CNT_EN
    assign stall_cnt_o = 32'd0;
    assign dgnt_cnt_o  = 32'd0;
`endif

    // Environment memory: 16 words, one-cycle registered read.
    logic [31:0] tb_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'd0;
        mem_rdata = 32'd0;
    end
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr[5:2]];
    end

    // Reference model state: 0 = sharing, 1 = draining, 2 = DMA owns the port.
    int          m_mode;
    int          m_starve;
    int          m_pend;          // 0 none, 1 core, 2 dma
    logic [31:0] m_pend_data;
    logic [31:0] m_core_last, m_dma_last;
    logic [31:0] m_mem [16];
    logic [31:0] m_stall_cnt, m_dgnt_cnt;

    task automatic model_reset();
        m_mode      = 0;
        m_starve    = 0;
        m_pend      = 0;
        m_pend_data = 32'd0;
        m_core_last = 32'd0;
        m_dma_last  = 32'd0;
        m_stall_cnt = 32'd0;
        m_dgnt_cnt  = 32'd0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
    endtask

    task automatic model_step(input stim_t s);
        exp_t        e;
        logic        cg, dg;
        logic [31:0] a;
        e  = '0;
        cg = 1'b0;
        dg = 1'b0;
        if (m_mode == 0) begin
            if (s.core_req && s.dma_req) begin
                if (m_starve == int'(LIM)) dg = 1'b1;
                else cg = 1'b1;
            end else begin
                cg = s.core_req;
                dg = s.dma_req;
            end
        end else if (m_mode == 2) begin
            dg = s.dma_req;
        end
        e.core_gnt   = cg;
        e.dma_gnt    = dg;
        e.core_stall = s.core_req && !cg;
        e.ack        = (m_mode == 2);
        e.core_rv    = (m_pend == 1) && !s.rst;
        e.dma_rv     = (m_pend == 2) && !s.rst;
        e.core_rdata = e.core_rv ? m_pend_data : m_core_last;
        e.dma_rdata  = e.dma_rv ? m_pend_data : m_dma_last;
        if (cg) begin
            e.mem_addr = s.core_addr; e.mem_wdata = s.core_wdata; e.mem_we = s.core_we;
        end else if (dg) begin
            e.mem_addr = s.dma_addr; e.mem_wdata = s.dma_wdata; e.mem_we = s.dma_we;
        end
        e.stall_cnt = m_stall_cnt;
        e.dgnt_cnt  = m_dgnt_cnt;
        exp_q.push_back(e);

        a = e.mem_addr;
        if (s.rst) begin
            m_mode = 0; m_starve = 0; m_pend = 0;
            m_core_last = 32'd0; m_dma_last = 32'd0;
            m_stall_cnt = 32'd0; m_dgnt_cnt = 32'd0;
        end else begin
            if (e.core_rv) m_core_last = m_pend_data;
            if (e.dma_rv) m_dma_last = m_pend_data;
            m_pend = 0;
            if ((cg || dg) && !e.mem_we) begin
                m_pend      = cg ? 1 : 2;
                m_pend_data = m_mem[a[5:2]];
            end
            if (dg || !s.dma_req) m_starve = 0;
            else if (cg && s.dma_req && m_starve < int'(LIM)) m_starve++;
            if (m_mode == 0) m_mode = s.dma_hold ? 1 : 0;
            else if (m_mode == 1) m_mode = s.dma_hold ? 2 : 0;
            else m_mode = s.dma_hold ? 2 : 0;
            if (e.core_stall) m_stall_cnt = m_stall_cnt + 32'd1;
            if (dg) m_dgnt_cnt = m_dgnt_cnt + 32'd1;
        end
        if ((cg || dg) && e.mem_we) m_mem[a[5:2]] = e.mem_wdata;
    endtask

    task automatic set_inputs(input stim_t s);
        rst        = s.rst;
        core_req   = s.core_req;
        core_we    = s.core_we;
        core_addr  = s.core_addr;
        core_wdata = s.core_wdata;
        dma_req    = s.dma_req;
        dma_we     = s.dma_we;
        dma_addr   = s.dma_addr;
        dma_wdata  = s.dma_wdata;
        dma_hold   = s.dma_hold;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        set_inputs(s);
        model_step(s);
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        return a;
    endfunction

    // Monitor: pops one expectation per presented cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctrl",
                    96'({core_gnt, core_stall, core_rvalid, dma_gnt, dma_hold_ack, dma_rvalid,
                         mem_we}),
                    96'({e.core_gnt, e.core_stall, e.core_rv, e.dma_gnt, e.ack, e.dma_rv,
                         e.mem_we}));
                chk("mem_bus", 96'({mem_addr, mem_wdata}), 96'({e.mem_addr, e.mem_wdata}));
                chk("rdata", 96'({core_rdata, dma_rdata}), 96'({e.core_rdata, e.dma_rdata}));
`ifdef ARB_PERF_CNT_EN
                chk("perf_cnt", 96'({stall_cnt_o, dgnt_cnt_o}),
                    96'({e.stall_cnt, e.dgnt_cnt}));
`endif
            end
        end
    end

    initial begin
        stim_t s;
        logic  hold_lvl;
        s = '0;
        s.rst = 1'b1;
        set_inputs(s);
        repeat (3) @(posedge clk);
        model_reset();

        // Reset state with idle inputs.
        s = '0;
        step(s);
        step(s);

        // Core write then read back 0xDEADBEEF at 0x10.
        s = '0; s.core_req = 1'b1; s.core_we = 1'b1;
        s.core_addr = 32'h10; s.core_wdata = 32'hDEADBEEF;
        step(s);
        s = '0; s.core_req = 1'b1; s.core_addr = 32'h10;
        step(s);
        s = '0;
        step(s);

        // Continuous contention: core x4 then one DMA slot.
        for (int i = 0; i < 12; i++) begin
            s = '0; s.core_req = 1'b1; s.dma_req = 1'b1;
            s.core_addr = rnd_addr(); s.dma_addr = rnd_addr();
            step(s);
        end
        s = '0;
        step(s);

        // Core write 0x20 against DMA read 0x40, DMA follows.
        s = '0; s.core_req = 1'b1; s.core_we = 1'b1; s.core_addr = 32'h20;
        s.core_wdata = 32'h5; s.dma_req = 1'b1; s.dma_addr = 32'h40;
        step(s);
        s = '0; s.dma_req = 1'b1; s.dma_addr = 32'h40;
        step(s);
        s = '0;
        step(s);

        // Hold sequence with core requesting throughout.
        for (int c = 0; c < 14; c++) begin
            s = '0; s.core_req = 1'b1; s.core_addr = rnd_addr();
            s.dma_hold = (c >= 1 && c < 10);
            s.dma_req = c[0]; s.dma_we = c[1]; s.dma_addr = rnd_addr();
            s.dma_wdata = $urandom;
            step(s);
        end

        // Reset the cycle after a DMA read grant.
        s = '0; s.dma_req = 1'b1; s.dma_addr = 32'h40;
        step(s);
        s = '0; s.rst = 1'b1;
        step(s);
        s = '0;
        step(s);
        step(s);

        // Randomized traffic.
        hold_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) hold_lvl = ~hold_lvl;
            s = '0;
            s.rst        = ($urandom_range(0, 96) == 0);
            s.core_req   = ($urandom_range(0, 3) != 0);
            s.core_we    = $urandom_range(0, 1) == 1;
            s.core_addr  = rnd_addr();
            s.core_wdata = $urandom;
            s.dma_req    = ($urandom_range(0, 2) != 0);
            s.dma_we     = $urandom_range(0, 1) == 1;
            s.dma_addr   = rnd_addr();
            s.dma_wdata  = $urandom;
            s.dma_hold   = hold_lvl;
            step(s);
        end
        s = '0;
        step(s);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
